dm_readback: RTL and testbench

Data-memory readback engine for the pipelined CPU environment. After a program run it walks a contiguous window of the data memory, reading one word at a time through the memory's synchronous read port, and streams each (address, word) pair out over a valid/ready interface to a checker or host. It is the read-side counterpart to the bench-side memory preload: preload writes the image in, `dm_readback` reads the result out.

---
 rtl/dm_readback_if.sv | 42 ++++
 rtl/dm_readback.sv | 193 +++++++++++++++++++
 tb/tb_dm_readback.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dm_readback_if.sv
// -----------------------------------------------------------------------------
// dm_readback_if
//   Bundles the start command, data-memory read port, output stream and status
//   signals of the dm_readback engine.
//
//   Command : Start, StartAddr[ADDR_W], Count[ADDR_W+1]
//   Memory  : MemRd, MemAddr[ADDR_W] (engine drives), MemData[DATA_W] (memory
//             drives, valid the cycle after MemRd)
//   Stream  : OutValid, OutAddr, OutData (engine drives), OutReady (consumer)
//   Status  : Busy, Done, Checksum
//
//   slave  : the readback engine's view.
//   master : the host/memory/consumer environment's view.
// -----------------------------------------------------------------------------
interface dm_readback_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              Start;
  logic [ADDR_W-1:0] StartAddr;
  logic [ADDR_W:0]   Count;
  logic              MemRd;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic              OutValid;
  logic              OutReady;
  logic [ADDR_W-1:0] OutAddr;
  logic [DATA_W-1:0] OutData;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Checksum;

  modport slave (
    input  Start, StartAddr, Count, MemData, OutReady,
    output MemRd, MemAddr, OutValid, OutAddr, OutData, Busy, Done, Checksum
  );

  modport master (
    output Start, StartAddr, Count, MemData, OutReady,
    input  MemRd, MemAddr, OutValid, OutAddr, OutData, Busy, Done, Checksum
  );
endinterface

// File: rtl/dm_readback.sv
// -----------------------------------------------------------------------------
// dm_readback
//   Walks a contiguous window of data memory after a program run, reading one
//   word at a time through the memory's synchronous read port, and streams
//   each (address, word) pair out over a valid/ready handshake.
//
//   Ports
//     Clock   : sole clock, rising edge.
//     Reset_n : asynchronous active-low reset.
//     bus     : dm_readback_if.slave -- command, memory read port, output
//               stream, Busy/Done status and running Checksum.
//
//   Per word the engine spends one cycle issuing the read (ISSUE), one cycle
//   capturing the returned data (WAIT), and at least one cycle presenting it
//   (OUT). The address counter wraps modulo 2^ADDR_W, so a Count of
//   2^ADDR_W visits every word exactly once.
//
//   Optional feature macro: DM_READBACK_CHECKSUM_EN
//     defined     : Checksum is the modulo-2^DATA_W sum of all streamed words,
//                   cleared on Start, updated on each handshake edge.
//     not defined : accumulator removed, Checksum tied to zero.
//
//   All interface outputs come straight from flops; each is loaded from the
//   next-state decode so it lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module dm_readback #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic          Clock,
  input  logic          Reset_n,
  dm_readback_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;      // next word to read
  logic [ADDR_W:0]   rem_q,      rem_d;       // words still to stream
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              mem_rd_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              start_take;
  logic              handshake;

  // Command acceptance and stream handshake qualifiers.
  always_comb begin
    start_take = (state_q == S_IDLE) && bus.Start;
    handshake  = (state_q == S_OUT) && bus.OutReady;
  end

  // Next-state, counter and output-register loading decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          addr_d = bus.StartAddr;
          rem_d  = bus.Count;
          if (bus.Count == {(ADDR_W+1){1'b0}}) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Memory data for the read issued last cycle is valid now.
        out_data_d = bus.MemData;
        out_addr_d = addr_q;
        state_d    = S_OUT;
      end

      S_OUT: begin
        if (bus.OutReady) begin
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          rem_d  = rem_q - {{ADDR_W{1'b0}}, 1'b1};
          // rem_q == 1 means this handshake consumed the last word.
          if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_OUT;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // MemAddr only moves when a read is about to be issued, so it keeps its
    // last value through WAIT/OUT/FIN/IDLE.
    if (state_d == S_ISSUE) begin
      mem_addr_d = addr_d;
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // State, counters and registered interface outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      rem_q       <= {(ADDR_W+1){1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      out_addr_q  <= {ADDR_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      mem_rd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      mem_addr_q  <= mem_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      mem_rd_q    <= (state_d == S_ISSUE);
      out_valid_q <= (state_d == S_OUT);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
    end
  end

`ifdef DM_READBACK_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Checksum next value: cleared by an accepted Start, accumulates each
  // streamed word on its handshake (carry out discarded).
  always_comb begin
    if (start_take) begin
      csum_d = {DATA_W{1'b0}};
    end else if (handshake) begin
      csum_d = csum_q + out_data_q;
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      csum_q <= {DATA_W{1'b0}};
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.Checksum = csum_q;
`else
  assign bus.Checksum = {DATA_W{1'b0}};
`endif

  assign bus.MemRd    = mem_rd_q;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.OutValid = out_valid_q;
  assign bus.OutAddr  = out_addr_q;
  assign bus.OutData  = out_data_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_dm_readback.sv
// -----------------------------------------------------------------------------
// tb_dm_readback
//   Self-checking bench for dm_readback. A memory array with a synchronous
//   read port backs the engine; the expected stream for each window is built
//   up front from the window rules (address = start + i mod 256, word =
//   mem[address], checksum = sum of words mod 2^32) and compared against the
//   DUT as words are handshaken.
// -----------------------------------------------------------------------------
module tb_dm_readback;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } word_t;

  logic Clock = 1'b0;
  logic Reset_n;

  dm_readback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Synchronous-read data memory: data valid the cycle after MemRd.
  always @(posedge Clock) begin
    if (bus.MemRd) bus.MemData <= mem[bus.MemAddr];
  end

  int    n_vec = 0;
  int    n_err = 0;
  word_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // mode 0: OutReady always 1; mode 1: random OutReady; mode 2: 5 stall
  // cycles per word. poke: pulse Start with junk parameters while busy.
  task automatic run_window(input logic [ADDR_W-1:0] sa, input int cnt,
                            input int mode, input bit poke);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] exp_sum;
    logic [ADDR_W-1:0] held_a;
    logic [DATA_W-1:0] held_d;
    logic              ready;
    bit                holding;
    bit                finished;
    int                reads, hs_n, done_due, first_valid, prev_hs, vcnt, budget;
    word_t             w;

    exp_q.delete();
    sum = '0;
    for (int i = 0; i < cnt; i++) begin
      w.a = sa + i[ADDR_W-1:0];
      w.d = mem[w.a];
      exp_q.push_back(w);
      sum += w.d;
    end
`ifdef DM_READBACK_CHECKSUM_EN
    exp_sum = sum;
`else
    exp_sum = '0;
`endif

    @(negedge Clock);
    bus.StartAddr = sa;
    bus.Count     = cnt[ADDR_W:0];
    bus.Start     = 1'b1;
    bus.OutReady  = 1'b0;
    @(negedge Clock);
    bus.Start = 1'b0;

    reads = 0; hs_n = 0; first_valid = -1; prev_hs = -1; vcnt = 0;
    holding = 1'b0; finished = 1'b0; held_a = '0; held_d = '0;
    done_due = (cnt == 0) ? 1 : -1;
    budget = cnt * 12 + 10;

    for (int c = 1; c <= budget && !finished; c++) begin
      check_eq("done", bus.Done, (c == done_due));
      check_eq("busy", bus.Busy, (done_due < 0) || (c <= done_due));
      if (c == 1) check_eq("memrd_after_start", bus.MemRd, (cnt != 0));
      if (done_due >= 0 && c == done_due + 1) finished = 1'b1;
      if (bus.Done) begin
        check_eq("checksum_at_done", bus.Checksum, exp_sum);
        check_eq("words_left_at_done", exp_q.size(), 0);
      end
      if (bus.MemRd) begin
        reads++;
        check_eq("memrd_with_valid", bus.OutValid, 1'b0);
        if (exp_q.size() > 0) check_eq("mem_addr", bus.MemAddr, exp_q[0].a);
      end
      if (holding) begin
        check_eq("hold_valid", bus.OutValid, 1'b1);
        check_eq("hold_addr", bus.OutAddr, held_a);
        check_eq("hold_data", bus.OutData, held_d);
      end

      ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.OutValid) begin
        vcnt++;
        if (mode == 2) ready = (vcnt > 5);
        if (first_valid < 0) begin
          first_valid = c;
          if (mode == 0) check_eq("first_word_latency", c, 3);
        end
        if (ready) begin
          hs_n++;
          if (exp_q.size() > 0) begin
            check_eq("out_addr", bus.OutAddr, exp_q[0].a);
            check_eq("out_data", bus.OutData, exp_q[0].d);
            void'(exp_q.pop_front());
          end
          if (mode == 0 && prev_hs >= 0) check_eq("word_interval", c - prev_hs, 3);
          prev_hs = c;
          holding = 1'b0;
          vcnt    = 0;
          if (exp_q.size() == 0) done_due = c + 1;
        end else begin
          holding = 1'b1;
          held_a  = bus.OutAddr;
          held_d  = bus.OutData;
        end
      end
      bus.OutReady = ready;

      bus.Start = 1'b0;
      if (poke && cnt != 0 && bus.Busy && !bus.Done && exp_q.size() > 0 &&
          $urandom_range(0, 2) == 0) begin
        bus.Start     = 1'b1;
        bus.StartAddr = ADDR_W'($urandom);
        bus.Count     = (ADDR_W+1)'($urandom_range(0, 256));
      end
      @(negedge Clock);
    end
    bus.Start = 1'b0;

    check_eq("window_finished", finished, 1'b1);
    check_eq("mem_reads", reads, cnt);
    check_eq("words_out", hs_n, cnt);
    check_eq("checksum_held", bus.Checksum, exp_sum);
  endtask

  task automatic reset_mid_run();
    bit got;
    @(negedge Clock);
    bus.StartAddr = ADDR_W'($urandom);
    bus.Count     = 9'd4;
    bus.Start     = 1'b1;
    bus.OutReady  = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (bus.OutValid) got = 1'b1;
      @(negedge Clock);
    end
    check_eq("rst_first_handshake", got, 1'b1);
    check_eq("rst_pre_memrd", bus.MemRd, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    check_eq("rst_async_memrd", bus.MemRd, 1'b0);
    check_eq("rst_async_valid", bus.OutValid, 1'b0);
    check_eq("rst_async_busy", bus.Busy, 1'b0);
    check_eq("rst_async_done", bus.Done, 1'b0);
    check_eq("rst_async_memaddr", bus.MemAddr, 0);
    check_eq("rst_async_outaddr", bus.OutAddr, 0);
    check_eq("rst_async_outdata", bus.OutData, 0);
    check_eq("rst_async_checksum", bus.Checksum, 0);
    bus.OutReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      check_eq("rst_hold_done", bus.Done, 1'b0);
      check_eq("rst_hold_memrd", bus.MemRd, 1'b0);
    end
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n       = 1'b0;
    bus.Start     = 1'b0;
    bus.StartAddr = '0;
    bus.Count     = '0;
    bus.OutReady  = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    #1;
    check_eq("reset_memrd", bus.MemRd, 1'b0);
    check_eq("reset_valid", bus.OutValid, 1'b0);
    check_eq("reset_busy", bus.Busy, 1'b0);
    check_eq("reset_done", bus.Done, 1'b0);
    check_eq("reset_memaddr", bus.MemAddr, 0);
    check_eq("reset_outaddr", bus.OutAddr, 0);
    check_eq("reset_outdata", bus.OutData, 0);
    check_eq("reset_checksum", bus.Checksum, 0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    mem[0] = 32'd8;
    mem[1] = 32'd1;
    run_window(8'h00, 2, 0, 1'b0);
    run_window(8'h00, 2, 2, 1'b0);

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = i;
    run_window(8'hFE, 4, 0, 1'b0);
    run_window(8'h10, 0, 0, 1'b0);

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    run_window(8'h40, 6, 0, 1'b1);
    run_window(8'h80, 256, 0, 1'b0);

    reset_mid_run();
    run_window(8'hFD, 5, 0, 1'b0);

    for (int k = 0; k < 15; k++) begin
      run_window(ADDR_W'($urandom), $urandom_range(0, 9), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
